// File: rtl/systolic_fir_pkg.sv
// rtl/systolic_fir_pkg.sv - shared FIR geometry, coefficient type, reset coefficients and controller states
package systolic_fir_pkg;

    localparam int TAP   = 4;
    localparam int COE_W = 16;
    localparam int IDX_W = (TAP > 1) ? $clog2(TAP) : 1;

    typedef logic signed [COE_W-1:0] coe_t;

    // Element [0] is tap 0, so the rightmost entry in the concatenation is the first tap.
    localparam coe_t [TAP-1:0] COE = {coe_t'(129), coe_t'(-138), coe_t'(14), coe_t'(7)};

    typedef logic [2:0] fir_coe_state_t;

    localparam fir_coe_state_t ST_IDLE  = 3'd0;
    localparam fir_coe_state_t ST_LOAD  = 3'd1;
    localparam fir_coe_state_t ST_PEND  = 3'd2;
    localparam fir_coe_state_t ST_FLUSH = 3'd3;
    localparam fir_coe_state_t ST_SWAP  = 3'd4;

endpackage

// File: rtl/fir_coe_ctrl.sv
// rtl/fir_coe_ctrl.sv - shadow-loaded FIR coefficient bank with drain-then-swap sequencing
module fir_coe_ctrl
    import systolic_fir_pkg::*;
#(
    parameter int FLUSH_CYC = TAP + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  coe_t                 cfg_data,
    input  logic                 cfg_last,
    input  logic                 swap_req,
    output logic                 x_ready_o,
    output logic                 zero_o,
    output coe_t [TAP-1:0]       coe_o,
    output logic                 pend_o,
    output logic                 err_o
);

    localparam logic [7:0]       FLUSH_INIT = 8'(FLUSH_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TAP - 1);

    fir_coe_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    coe_t [TAP-1:0]   shadow_q, shadow_d;
    coe_t [TAP-1:0]   coe_q, coe_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             x_ready_q, x_ready_d;
    logic             zero_q, zero_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             load_bad;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        coe_d    = coe_q;
        err_d    = 1'b0;
        load_bad = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (cfg_valid && cfg_ready_q) begin
                    shadow_d[idx_q] = cfg_data;
                    if (idx_q == IDX_LAST) begin
                        if (cfg_last) begin
                            state_d = ST_PEND;
                            idx_d   = '0;
                        end else begin
                            load_bad = 1'b1;
                        end
                    end else if (cfg_last) begin
                        load_bad = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                // A malformed set is dropped entirely; the active bank is untouched.
                if (load_bad) begin
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_PEND: begin
                if (swap_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SWAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SWAP: begin
                coe_d   = shadow_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = 8'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        x_ready_d   = (state_d != ST_FLUSH) && (state_d != ST_SWAP);
        zero_d      = (state_d == ST_FLUSH);
        pend_d      = (state_d == ST_PEND) || (state_d == ST_FLUSH) || (state_d == ST_SWAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= 8'd0;
            shadow_q    <= '0;
            coe_q       <= COE;
            cfg_ready_q <= 1'b1;
            x_ready_q   <= 1'b1;
            zero_q      <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            coe_q       <= coe_d;
            cfg_ready_q <= cfg_ready_d;
            x_ready_q   <= x_ready_d;
            zero_q      <= zero_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign x_ready_o = x_ready_q;
    assign zero_o    = zero_q;
    assign coe_o     = coe_q;
    assign pend_o    = pend_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_fir_coe_ctrl.sv
// tb/tb_fir_coe_ctrl.sv - vector-table bench for fir_coe_ctrl with a drain-length sequence
module tb_fir_coe_ctrl;
    import systolic_fir_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    coe_t           cfg_data;
    logic           cfg_last;
    logic           swap_req;
    logic           x_ready_o;
    logic           zero_o;
    coe_t [TAP-1:0] coe_o;
    logic           pend_o;
    logic           err_o;

    fir_coe_ctrl #(.FLUSH_CYC(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .swap_req  (swap_req),
        .x_ready_o (x_ready_o),
        .zero_o    (zero_o),
        .coe_o     (coe_o),
        .pend_o    (pend_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic v;
        coe_t d;
        logic l;
        logic sw;
        logic rdy;
        logic xr;
        logic z;
        logic p;
        logic e;
        int   sel;
    } vec_t;

    vec_t           tbl[$];
    coe_t [TAP-1:0] exp_set [0:4];
    int             n_vec = 0;
    int             n_bad = 0;

    task automatic mkset(input int i, input int a, input int b, input int c, input int d);
        exp_set[i][0] = coe_t'(a);
        exp_set[i][1] = coe_t'(b);
        exp_set[i][2] = coe_t'(c);
        exp_set[i][3] = coe_t'(d);
    endtask

    task automatic add(input logic r, input logic v, input int d, input logic l, input logic sw,
                       input logic rdy, input logic xr, input logic z, input logic p, input logic e,
                       input int sel);
        vec_t t;
        t.rst = r; t.v = v; t.d = coe_t'(d); t.l = l; t.sw = sw;
        t.rdy = rdy; t.xr = xr; t.z = z; t.p = p; t.e = e; t.sel = sel;
        tbl.push_back(t);
    endtask

    task automatic idle(input int sel);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, sel);
    endtask

    task automatic word(input int d, input int sel);
        add(0, 1, d, 0, 0, 1, 1, 0, 0, 0, sel);
    endtask

    task automatic word_last(input int d, input int sel);
        add(0, 1, d, 1, 0, 0, 1, 0, 1, 0, sel);
    endtask

    // From PEND: swap edge, six drain cycles (junk cfg/swap ignored), one SWAP cycle, then IDLE.
    task automatic swap_seq(input int old_sel, input int new_sel);
        add(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, old_sel);
        for (int i = 0; i < 5; i++) add(0, 1, 77, 1, 1, 0, 0, 1, 1, 0, old_sel);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, old_sel);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, new_sel);
    endtask

    task automatic step(input logic r, input logic v, input int d, input logic l, input logic sw);
        rst = r; cfg_valid = v; cfg_data = coe_t'(d); cfg_last = l; swap_req = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ok, input string detail);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    initial begin
        int n;
        int w;

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; swap_req = 1'b0;

        mkset(0, 7, 14, -138, 129);
        mkset(1, 1, 2, 3, 4);
        mkset(2, 5, 6, 7, 8);
        mkset(3, -1, 100, -32768, 32767);
        mkset(4, 13, 14, 15, 16);

        add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) idle(0);
        word(1, 0); word(2, 0); word(3, 0); word_last(4, 0);
        add(0, 1, 99, 1, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        swap_seq(0, 1);
        idle(1);
        word(50, 1);
        add(0, 1, 60, 1, 0, 1, 1, 0, 0, 1, 1);
        idle(1);
        word(9, 1); word(9, 1); word(9, 1);
        add(0, 1, 9, 0, 0, 1, 1, 0, 0, 1, 1);
        idle(1);
        add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        word(5, 1);
        add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        word(6, 1); word(7, 1); word_last(8, 1);
        swap_seq(1, 2);
        word(-1, 2); word(100, 2); word(-32768, 2); word_last(32767, 2);
        swap_seq(2, 3);
        idle(3);
        word(11, 3); word(22, 3); word(33, 3); word_last(44, 3);
        add(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3);
        add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) idle(0);

        foreach (tbl[i]) begin
            vec_t t;
            t = tbl[i];
            step(t.rst, t.v, t.d, t.l, t.sw);
            check($sformatf("vec%0d", i),
                  cfg_ready === t.rdy && x_ready_o === t.xr && zero_o === t.z &&
                  pend_o === t.p && err_o === t.e && coe_o === exp_set[t.sel],
                  $sformatf("got rdy=%b xr=%b z=%b p=%b e=%b coe=%h, want rdy=%b xr=%b z=%b p=%b e=%b coe=%h",
                            cfg_ready, x_ready_o, zero_o, pend_o, err_o, coe_o,
                            t.rdy, t.xr, t.z, t.p, t.e, exp_set[t.sel]));
        end

        step(0, 1, 21, 0, 0);
        step(0, 1, 22, 0, 0);
        step(0, 1, 23, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_mid_load", pend_o === 1'b0 && cfg_ready === 1'b1 && coe_o === exp_set[0],
              $sformatf("got p=%b rdy=%b coe=%h", pend_o, cfg_ready, coe_o));
        step(0, 1, 13, 0, 0);
        step(0, 1, 14, 0, 0);
        step(0, 1, 15, 0, 0);
        step(0, 1, 16, 1, 0);
        check("reload_pend", pend_o === 1'b1 && cfg_ready === 1'b0,
              $sformatf("got p=%b rdy=%b want p=1 rdy=0", pend_o, cfg_ready));
        step(0, 0, 0, 0, 1);
        n = 0;
        while (zero_o === 1'b1 && n < 100) begin
            n++;
            step(0, 0, 0, 0, 0);
        end
        check("flush_len", n == 6, $sformatf("got %0d drain cycles want 6", n));
        w = 0;
        while (x_ready_o !== 1'b1 && w < 20) begin
            w++;
            step(0, 0, 0, 0, 0);
        end
        check("swap_done", w == 1 && x_ready_o === 1'b1 && pend_o === 1'b0 && coe_o === exp_set[4],
              $sformatf("got wait=%0d xr=%b p=%b coe=%h want wait=1 xr=1 p=0 coe=%h",
                        w, x_ready_o, pend_o, coe_o, exp_set[4]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_coe_ctrl.md
FIR_COE_CTRL -- requirements
Module: fir_coe_ctrl

Interface
REQ-001 Parameter: FLUSH_CYC, default TAP+2, number of zero-input drain cycles before a coefficient swap (range 1..255).
REQ-002 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 Ports: rst  in  1  reset; synchronous and active-high.
REQ-004 Ports: cfg_valid  in  1  coefficient word valid.
REQ-005 Ports: cfg_ready  out  1  coefficient word accepted when cfg_valid && cfg_ready.
REQ-006 Ports: cfg_data  in  COE_W  signed coefficient word, tap 0 first.
REQ-007 Ports: cfg_last  in  1  marks final word of a set.
REQ-008 Ports: swap_req  in  1  request to apply the loaded set.
REQ-009 Ports: x_ready_o  out  1  upstream sample-stream ready; low while draining.
REQ-010 Ports: zero_o  out  1  forces FIR input sample to zero.
REQ-011 Ports: coe_o  out  TAP x coe_t  active coefficient array driving the FIR.
REQ-012 Ports: pend_o  out  1  complete shadow set waiting for swap.
REQ-013 Ports: err_o  out  1  one-cycle pulse on malformed load.

Function
REQ-014 FSM states IDLE, LOAD, PEND, FLUSH, SWAP; all outputs registered.
REQ-015 cfg_ready high in IDLE and LOAD only; low in PEND, FLUSH and SWAP.
REQ-016 Accepted word written to shadow[idx]; idx starts at 0 and increments per accepted word; IDLE->LOAD on the first accepted word.
REQ-017 Word accepted at idx==TAP-1 with cfg_last=1: set complete, go to PEND, pend_o=1 from next cycle.
REQ-018 cfg_last=1 at idx<TAP-1, or cfg_last=0 at idx==TAP-1: err_o pulses next cycle, shadow discarded, idx=0, return to IDLE; coe_o unchanged.
REQ-019 swap_req sampled only in PEND; ignored in IDLE, LOAD, FLUSH, SWAP (not latched).
REQ-020 swap_req=1 in PEND at edge k: FLUSH during cycles k+1..k+FLUSH_CYC with x_ready_o=0 and zero_o=1; SWAP in cycle k+FLUSH_CYC+1 (x_ready_o=0, zero_o=0).
REQ-021 SWAP copies all TAP shadow words to coe_o in one edge; new coe_o, x_ready_o=1, pend_o=0, state IDLE from cycle k+FLUSH_CYC+2.
REQ-022 Flush counter 8-bit, loaded with FLUSH_CYC-1 on entering FLUSH, decremented to 0; no wrap.
REQ-023 coe_o never changes except at a SWAP edge or reset; partially loaded words never reach coe_o.
REQ-024 x_ready_o=1 and zero_o=0 in IDLE, LOAD, PEND.

Reset
REQ-025 rst=1 at an edge: state IDLE, idx=0, flush counter 0, shadow cleared to 0, coe_o=COE package defaults, cfg_ready=1, x_ready_o=1, zero_o=0, pend_o=0, err_o=0.
REQ-026 Reset mid-LOAD, mid-PEND or mid-FLUSH discards the pending set and restores default coe_o; no swap completes.

Structure
REQ-027 TAP, COE_W, coe_t and the default COE array come from systolic_fir_pkg; add fsm state typedef fir_coe_state_t to that package.
REQ-028 Single module, no sub-modules; flush counter and shadow bank inline.

Verification
REQ-029 Reset then idle 10 cycles -> coe_o={7,14,-138,129}, cfg_ready=1, x_ready_o=1, err_o never asserted.
REQ-030 Load {1,2,3,4} with last on 4th word, swap_req at edge k, FLUSH_CYC=6 -> x_ready_o=0/zero_o=1 cycles k+1..k+6, coe_o={1,2,3,4} from k+8.
REQ-031 Load 2 words with cfg_last on 2nd -> err_o pulse 1 cycle, coe_o unchanged, next clean load succeeds.
REQ-032 swap_req during LOAD and in IDLE, cfg_valid during PEND/FLUSH -> no swap, no word accepted (cfg_ready=0 in PEND/FLUSH).
REQ-033 rst asserted at FLUSH cycle 3 -> next cycle coe_o=defaults, x_ready_o=1, pend_o=0.
REQ-034 Back-to-back loads: second load starts same cycle as first returns to IDLE -> both swaps complete in order, coe_o shows each set.
